seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_if.sv | 22 ++
 rtl/seg7_scan.sv | 124 ++++++++++++
 tb/tb_seg7_scan.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Load handshake and scan outputs of the 4-digit multiplexed 7-segment scanner.
// The master side supplies values; the slave side is the scanner.
interface seg7_scan_if;
    logic        load;
    logic [15:0] value;
    logic        lz_blank;
    logic        ready;
    logic [3:0]  nibble;
    logic [3:0]  digit_en;
    logic        blank;
    logic        frame_tick;

    modport master (
        output load, value, lz_blank,
        input  ready, nibble, digit_en, blank, frame_tick
    );

    modport slave (
        input  load, value, lz_blank,
        output ready, nibble, digit_en, blank, frame_tick
    );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit hex display scanner: ON/DEAD time multiplexing with a pending
// register so a new value only replaces the display on a frame boundary.
module seg7_scan #(
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam logic [19:0] ON_LAST   = 20'(CLK_DIV - 1);
    localparam logic [19:0] DEAD_LAST = 20'(DEAD_CYC - 1);

    typedef enum logic {ST_DEAD, ST_ON} state_t;

    state_t      state_q, state_d;
    logic [1:0]  d_q, d_d;
    logic [19:0] cnt_q, cnt_d;
    logic        init_q, init_d;
    logic [15:0] disp_q, disp_d, pend_q, pend_d;
    logic        lz_q, lz_d, pend_lz_q, pend_lz_d;
    logic        ready_q, ready_d;
    logic [3:0]  nib_q, nib_d, en_q, en_d;
    logic        blank_q, blank_d, tick_q, tick_d;
    logic [3:0]  zero_above;

    // zero_above[i]: digit i and every more significant digit are zero
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_zero
            assign zero_above[gi] = (disp_d[15:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        cnt_d     = cnt_q + 20'd1;
        init_d    = init_q;
        disp_d    = disp_q;
        lz_d      = lz_q;
        pend_d    = pend_q;
        pend_lz_d = pend_lz_q;
        ready_d   = ready_q;
        case (state_q)
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    d_d     = d_q + 2'd1;
                    init_d  = 1'b0;
                end
            end
        endcase
        // A frame boundary commits the pending value; a same-cycle load waits a frame
        if (tick_q && !ready_q) begin
            disp_d  = pend_q;
            lz_d    = pend_lz_q;
            ready_d = 1'b1;
        end
        if (bus.load && ready_q) begin
            pend_d    = bus.value;
            pend_lz_d = bus.lz_blank;
            ready_d   = 1'b0;
        end
    end

    // Outputs are derived from next-state values so they switch with the state
    always_comb begin
        en_d    = '0;
        nib_d   = nib_q;
        blank_d = 1'b1;
        if (state_d == ST_ON) begin
            en_d    = 4'b0001 << d_d;
            nib_d   = disp_d[{d_d, 2'b00} +: 4];
            blank_d = lz_d && (d_d != 2'd0) && zero_above[d_d];
        end
        tick_d = (state_d == ST_DEAD) && (d_d == 2'd3) && (cnt_d == DEAD_LAST) && !init_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_DEAD;
            d_q       <= 2'd3;
            cnt_q     <= '0;
            init_q    <= 1'b1;
            disp_q    <= '0;
            pend_q    <= '0;
            lz_q      <= 1'b0;
            pend_lz_q <= 1'b0;
            ready_q   <= 1'b1;
            nib_q     <= '0;
            en_q      <= '0;
            blank_q   <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            init_q    <= init_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            lz_q      <= lz_d;
            pend_lz_q <= pend_lz_d;
            ready_q   <= ready_d;
            nib_q     <= nib_d;
            en_q      <= en_d;
            blank_q   <= blank_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.nibble     = nib_q;
    assign bus.digit_en   = en_q;
    assign bus.blank      = blank_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: the driver queues the digits each frame must
// show; a monitor pops one entry at the start of every ON phase.
module tb_seg7_scan;
    localparam int CLK_DIV  = 4;
    localparam int DEAD_CYC = 2;
    localparam int FRAME    = 4 * (CLK_DIV + DEAD_CYC);

    logic clk = 1'b0;
    logic rst = 1'b0;

    seg7_scan_if bus ();

    seg7_scan #(.CLK_DIV(CLK_DIV), .DEAD_CYC(DEAD_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] nib;
        logic       blk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // mask bit i = expected blank for digit i
    task automatic push_frame(input logic [15:0] v, input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.en  = 4'(1 << i);
            e.nib = v[4*i +: 4];
            e.blk = mask[i];
            sb.push_back(e);
        end
    endtask

    task automatic wait_tick();
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            if (bus.frame_tick) return;
        end
        checks++;
        errors++;
        $display("FAIL tick_timeout: no frame_tick within %0d cycles, expected one", 2 * FRAME);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_once(input logic [15:0] v, input logic lz);
        chk("ready_before_load", bus.ready, 1);
        bus.load     = 1'b1;
        bus.value    = v;
        bus.lz_blank = lz;
        @(negedge clk);
        bus.load = 1'b0;
        chk("ready_after_load", bus.ready, 0);
    endtask

    initial begin : monitor
        int         since;
        int         on_len;
        int         last_tick;
        int         first_on;
        logic [3:0] prev_en;
        exp_t       e;
        since = 0; on_len = 0; last_tick = -1; first_on = -1; prev_en = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                since = 0; on_len = 0; last_tick = -1; first_on = -1; prev_en = '0;
            end else begin
                since++;
                if (bus.digit_en != 4'b0000) begin
                    if (prev_en == 4'b0000) begin
                        if (first_on < 0) begin
                            first_on = since;
                            chk("first_on_delay", since, DEAD_CYC);
                        end
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_underflow: digit_en=%b shown, expected no ON phase", bus.digit_en);
                        end else begin
                            e = sb.pop_front();
                            $display("digit_en=%b nibble=%h blank=%b (exp %b %h %b)",
                                     bus.digit_en, bus.nibble, bus.blank, e.en, e.nib, e.blk);
                            chk("digit_en", bus.digit_en, e.en);
                            chk("nibble", bus.nibble, e.nib);
                            chk("blank_on", bus.blank, e.blk);
                        end
                        on_len = 0;
                    end
                    on_len++;
                end else begin
                    if (prev_en != 4'b0000) chk("on_len", on_len, CLK_DIV);
                    chk("dead_blank", bus.blank, 1);
                end
                if (bus.frame_tick) begin
                    if (last_tick < 0) chk("first_tick", since, DEAD_CYC + FRAME - 1);
                    else               chk("tick_period", since - last_tick, FRAME);
                    chk("tick_in_dead", bus.digit_en, 0);
                    last_tick = since;
                end
                prev_en = bus.digit_en;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic found;
        bus.load = 1'b0; bus.value = '0; bus.lz_blank = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_digit_en", bus.digit_en, 0);
        chk("rst_nibble", bus.nibble, 0);
        chk("rst_blank", bus.blank, 1);
        chk("rst_ready", bus.ready, 1);
        chk("rst_tick", bus.frame_tick, 0);
        repeat (3) @(negedge clk);
        push_frame(16'h0000, 4'b0000);
        #1 rst = 1'b0;

        wait_tick();
        push_frame(16'h0000, 4'b0000);
        idle(5);
        load_once(16'h1A3F, 1'b0);
        bus.load = 1'b1; bus.value = 16'hBEEF; bus.lz_blank = 1'b1;
        @(negedge clk);
        chk("ready_while_busy", bus.ready, 0);
        @(negedge clk);
        bus.load = 1'b0;

        wait_tick();
        chk("ready_at_tick", bus.ready, 0);
        push_frame(16'h1A3F, 4'b0000);
        @(negedge clk);
        chk("ready_after_transfer", bus.ready, 1);
        idle(3);
        load_once(16'h0042, 1'b1);

        wait_tick();
        push_frame(16'h0042, 4'b1100);
        idle(4);
        load_once(16'h0000, 1'b1);

        wait_tick();
        push_frame(16'h0000, 4'b1110);

        wait_tick();
        push_frame(16'h0000, 4'b1110);
        chk("ready_at_coincident_tick", bus.ready, 1);
        bus.load = 1'b1; bus.value = 16'h5C07; bus.lz_blank = 1'b0;
        @(negedge clk);
        bus.load = 1'b0;
        chk("ready_after_coincident", bus.ready, 0);

        wait_tick();
        push_frame(16'h5C07, 4'b0000);
        idle(2);
        load_once(16'h9999, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            @(negedge clk);
            if (bus.digit_en == 4'b0100) found = 1'b1;
        end
        chk("reach_digit2", found, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst2_digit_en", bus.digit_en, 0);
        chk("rst2_nibble", bus.nibble, 0);
        chk("rst2_blank", bus.blank, 1);
        chk("rst2_ready", bus.ready, 1);
        chk("rst2_tick", bus.frame_tick, 0);
        chk("rst2_leftover", sb.size(), 1);
        sb.delete();

        repeat (2) @(negedge clk);
        push_frame(16'h0000, 4'b0000);
        #1 rst = 1'b0;
        wait_tick();
        push_frame(16'h0000, 4'b0000);
        wait_tick();
        chk("sb_drained", sb.size(), 0);
        chk("final_ready", bus.ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
